// File: rtl/seg7_multi.sv
// Multi-digit seven-segment driver: latches packed nibbles on a load strobe and
// drives registered active-low segments with decimal mode, leading-zero blanking and blink.
module seg7_multi #(
    parameter int NUM_DIGITS = 8,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic                    dec_mode,
    input  logic                    lzb_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [7*NUM_DIGITS-1:0] hex,
    output logic                    blink_phase
);

    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    logic [4*NUM_DIGITS-1:0] data_q, data_d;
    logic                    dec_q, dec_d;
    logic                    lzb_q, lzb_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    phase_q, phase_d;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;

    logic [6:0]              digit_seg [NUM_DIGITS];
    logic [NUM_DIGITS:0]     zero_above;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // Shadow registers and free-running blink prescaler (load never touches the prescaler).
    always_comb begin
        data_d  = data_q;
        dec_d   = dec_q;
        lzb_d   = lzb_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
        if (load) begin
            data_d = data;
            dec_d  = dec_mode;
            lzb_d  = lzb_en;
            mask_d = blink_mask;
        end
        if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    assign zero_above[NUM_DIGITS] = 1'b1;

    // zero_above[i] is set when nibble i and every higher nibble are zero.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] nib;
            logic       lz_blank;
            assign nib            = data_q[4*gi +: 4];
            assign zero_above[gi] = zero_above[gi+1] & (nib == 4'h0);
            if (gi == 0) begin : g_lsd
                assign lz_blank = 1'b0;
            end else begin : g_upper
                assign lz_blank = lzb_q & zero_above[gi];
            end
            assign digit_seg[gi] = (mask_q[gi] & phase_q)       ? SEG_BLANK :
                                   lz_blank                     ? SEG_BLANK :
                                   (dec_q && (nib > 4'd9))      ? SEG_DASH  :
                                                                  glyph(nib);
        end
    endgenerate

    always_comb begin
        hex_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            hex_d[7*i +: 7] = digit_seg[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            dec_q   <= 1'b0;
            lzb_q   <= 1'b0;
            mask_q  <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            hex_q   <= '1;
        end else begin
            data_q  <= data_d;
            dec_q   <= dec_d;
            lzb_q   <= lzb_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            hex_q   <= hex_d;
        end
    end

    assign hex         = hex_q;
    assign blink_phase = phase_q;

endmodule

// File: tb/tb_seg7_multi.sv
// Scoreboard bench for seg7_multi: loads push expected displays, checks pop them two edges later.
module tb_seg7_multi;

    localparam int ND = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [31:0]   data = '0;
    logic          dec_mode = 1'b0;
    logic          lzb_en = 1'b0;
    logic [7:0]    blink_mask = '0;
    logic [55:0]   hex;
    logic          blink_phase;

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct {
        logic [31:0] d;
        logic        dec;
        logic        lzb;
        logic [7:0]  m;
        string       name;
    } item_t;
    item_t sb[$];

    // Prescaler reference: 4-cycle half period, ph_prev is the phase seen by the last hex update.
    logic [1:0] cnt_m = '0;
    logic       ph_m = 1'b0;
    logic       ph_prev = 1'b0;

    seg7_multi #(.NUM_DIGITS(ND), .BLINK_DIV(4)) dut (
        .clk(clk), .rst(rst), .load(load), .data(data), .dec_mode(dec_mode),
        .lzb_en(lzb_en), .blink_mask(blink_mask), .hex(hex), .blink_phase(blink_phase)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ph_prev <= ph_m;
        if (rst) begin
            cnt_m <= '0;
            ph_m  <= 1'b0;
        end else if (cnt_m == 2'd3) begin
            cnt_m <= '0;
            ph_m  <= ~ph_m;
        end else begin
            cnt_m <= cnt_m + 2'd1;
        end
    end

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h40; 4'h1: g = 7'h79; 4'h2: g = 7'h24; 4'h3: g = 7'h30;
            4'h4: g = 7'h19; 4'h5: g = 7'h12; 4'h6: g = 7'h02; 4'h7: g = 7'h78;
            4'h8: g = 7'h00; 4'h9: g = 7'h10; 4'hA: g = 7'h08; 4'hB: g = 7'h03;
            4'hC: g = 7'h46; 4'hD: g = 7'h21; 4'hE: g = 7'h06; default: g = 7'h0E;
        endcase
        return g;
    endfunction

    function automatic logic [55:0] model(input item_t it, input logic ph);
        logic [55:0] r;
        logic        zr;
        logic [3:0]  nib;
        logic [6:0]  g;
        r  = '1;
        zr = 1'b1;
        for (int i = ND - 1; i >= 0; i--) begin
            nib = it.d[4*i +: 4];
            if (nib != 4'h0) zr = 1'b0;
            if (it.m[i] && ph)                 g = 7'h7F;
            else if (it.lzb && zr && i != 0)   g = 7'h7F;
            else if (it.dec && nib > 4'd9)     g = 7'h3F;
            else                               g = glyph(nib);
            r[7*i +: 7] = g;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_load(input logic [31:0] d, input logic dec, input logic lzb,
                              input logic [7:0] m, input string name);
        item_t it;
        it.d = d; it.dec = dec; it.lzb = lzb; it.m = m; it.name = name;
        data = d; dec_mode = dec; lzb_en = lzb; blink_mask = m; load = 1'b1;
        sb.push_back(it);
        step();
        load = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        checks_total++;
        if (hex !== {56{1'b1}}) $display("FAIL reset_blank hex=%h expected=%h", hex, {56{1'b1}});
        else checks_passed++;
        rst = 1'b0;
        step();
        checks_total++;
        if (hex !== {8{7'h40}} || blink_phase !== 1'b0)
            $display("FAIL reset_release hex=%h phase=%b expected=%h phase=0", hex, blink_phase, {8{7'h40}});
        else checks_passed++;
    endtask

    task automatic test_hex_decode();
        item_t e;
        logic [55:0] exp;
        drive_load(32'hFEDC_BA98, 1'b0, 1'b0, 8'h00, "hex_decode");
        e = sb.pop_front();
        exp = model(e, ph_prev);
        checks_total++;
        if (hex !== exp) $display("FAIL %s hex=%h expected=%h", e.name, hex, exp);
        else checks_passed++;
        checks_total++;
        if (hex[6:0] !== 7'h00 || hex[13:7] !== 7'h10 || hex[20:14] !== 7'h08 || hex[55:49] !== 7'h0E)
            $display("FAIL hex_digits d0=%h d1=%h d2=%h d7=%h expected=00 10 08 0e",
                     hex[6:0], hex[13:7], hex[20:14], hex[55:49]);
        else checks_passed++;
    endtask

    task automatic test_decimal();
        item_t e;
        logic [55:0] exp;
        drive_load(32'h0000_1A35, 1'b1, 1'b0, 8'h00, "decimal");
        e = sb.pop_front();
        exp = model(e, ph_prev);
        checks_total++;
        if (hex !== exp) $display("FAIL %s hex=%h expected=%h", e.name, hex, exp);
        else checks_passed++;
        checks_total++;
        if (hex[27:0] !== {7'h79, 7'h3F, 7'h30, 7'h12})
            $display("FAIL decimal_digits low4=%h expected=%h", hex[27:0], {7'h79, 7'h3F, 7'h30, 7'h12});
        else checks_passed++;
    endtask

    task automatic test_lzb();
        item_t e;
        logic [55:0] exp;
        drive_load(32'h0000_0102, 1'b0, 1'b1, 8'h00, "lzb_0102");
        e = sb.pop_front();
        exp = model(e, ph_prev);
        checks_total++;
        if (hex !== exp || hex !== {{5{7'h7F}}, 7'h79, 7'h40, 7'h24})
            $display("FAIL %s hex=%h expected=%h", e.name, hex, {{5{7'h7F}}, 7'h79, 7'h40, 7'h24});
        else checks_passed++;
        drive_load(32'h0, 1'b0, 1'b1, 8'h00, "lzb_zero");
        e = sb.pop_front();
        exp = model(e, ph_prev);
        checks_total++;
        if (hex !== exp || hex !== {{7{7'h7F}}, 7'h40})
            $display("FAIL %s hex=%h expected=%h", e.name, hex, {{7{7'h7F}}, 7'h40});
        else checks_passed++;
    endtask

    task automatic test_back_to_back();
        item_t e;
        logic [55:0] exp;
        item_t it;
        data = 32'h1111_1111; dec_mode = 1'b0; lzb_en = 1'b0; blink_mask = 8'h00; load = 1'b1;
        step();
        data = 32'h2222_2222;
        step();
        it.d = 32'h0000_0C3D; it.dec = 1'b0; it.lzb = 1'b1; it.m = 8'h00; it.name = "back_to_back";
        data = it.d; lzb_en = 1'b1;
        sb.push_back(it);
        step();
        load = 1'b0;
        step();
        e = sb.pop_front();
        exp = model(e, ph_prev);
        checks_total++;
        if (hex !== exp) $display("FAIL %s hex=%h expected=%h", e.name, hex, exp);
        else checks_passed++;
    endtask

    task automatic test_blink();
        item_t e;
        logic [55:0] exp;
        logic        last_ph;
        int          toggles;
        drive_load(32'h0000_0077, 1'b0, 1'b1, 8'h01, "blink_load");
        e = sb.pop_front();
        exp = model(e, ph_prev);
        checks_total++;
        if (hex !== exp) $display("FAIL %s hex=%h expected=%h", e.name, hex, exp);
        else checks_passed++;
        toggles = 0;
        last_ph = blink_phase;
        for (int c = 0; c < 16; c++) begin
            step();
            exp = model(e, ph_prev);
            checks_total++;
            if (hex !== exp || blink_phase !== ph_m || hex[13:7] !== 7'h78)
                $display("FAIL blink_cycle%0d hex=%h phase=%b expected=%h phase=%b", c, hex, blink_phase, exp, ph_m);
            else checks_passed++;
            if (blink_phase !== last_ph) toggles++;
            last_ph = blink_phase;
        end
        checks_total++;
        if (toggles != 4) $display("FAIL blink_toggles count=%0d expected=4", toggles);
        else checks_passed++;
    endtask

    task automatic test_collisions();
        item_t e;
        logic [55:0] exp;
        logic        ph_before;
        rst = 1'b1; load = 1'b1; data = 32'hDEAD_BEEF; lzb_en = 1'b0; dec_mode = 1'b0; blink_mask = 8'hFF;
        step();
        checks_total++;
        if (hex !== {56{1'b1}} || blink_phase !== 1'b0)
            $display("FAIL rst_load_blank hex=%h phase=%b expected=%h phase=0", hex, blink_phase, {56{1'b1}});
        else checks_passed++;
        rst = 1'b0; load = 1'b0;
        step();
        checks_total++;
        if (hex !== {8{7'h40}}) $display("FAIL rst_load_discard hex=%h expected=%h", hex, {8{7'h40}});
        else checks_passed++;
        for (int k = 0; k < 8 && cnt_m != 2'd3; k++) step();
        checks_total++;
        if (cnt_m != 2'd3) $display("FAIL wrap_wait cnt=%0d expected=3", cnt_m);
        else checks_passed++;
        ph_before = ph_m;
        drive_load(32'h0000_0005, 1'b0, 1'b0, 8'h01, "load_at_wrap");
        e = sb.pop_front();
        exp = model(e, ph_prev);
        checks_total++;
        if (hex !== exp || blink_phase !== ~ph_before ||
            hex[6:0] !== (ph_before ? 7'h12 : 7'h7F))
            $display("FAIL %s hex=%h phase=%b expected=%h phase=%b", e.name, hex, blink_phase, exp, ~ph_before);
        else checks_passed++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_hex_decode();
        test_decimal();
        test_lzb();
        test_back_to_back();
        test_blink();
        test_collisions();
        checks_total++;
        if (sb.size() != 0) $display("FAIL scoreboard_leftover size=%0d expected=0", sb.size());
        else checks_passed++;
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time=%0t expected=finish", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seg7_multi.md
# seg7_multi

Parametrised multi-digit seven-segment driver for the DE2 HEX displays: it replaces per-digit instances of the single-digit combinational decoder with one registered block. It latches a packed nibble vector on a load strobe and decodes every digit to active-low segments. Added behaviour: a hex/decimal mode, leading-zero blanking, and per-digit blinking from an internal prescaler. It sits between the clock/counter logic and the HEX pins.

## Interface
- NUM_DIGITS, 8, number of digits driven (1..8)
- BLINK_DIV, 25_000_000, clock cycles per blink half-period (>= 2)
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- load  input  1  single-cycle strobe; captures data/mode inputs
- data  input  4*NUM_DIGITS  packed nibbles; digit 0 = data[3:0] = least significant
- dec_mode  input  1  1 = decimal display; nibbles 10..15 show "-"
- lzb_en  input  1  1 = blank leading zeros
- blink_mask  input  NUM_DIGITS  bit i = 1 makes digit i blink
- hex  output  7*NUM_DIGITS  active-low segments {g,f,e,d,c,b,a}; digit i = hex[7i+6:7i]
- blink_phase  output  1  current blink phase (1 = blinking digits dark)

## Operation
- Shadow registers data_r, dec_r, lzb_r and mask_r are loaded only when load=1. Inputs are ignored otherwise.
- Glyph table (active low, index → pattern):
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000
  - 4:0011001, 5:0010010, 6:0000010, 7:1111000
  - 8:0000000, 9:0010000, A:0001000, b:0000011
  - C:1000110, d:0100001, E:0000110, F:0001110
  - Blank = 1111111; dash = 0111111.
- Decimal mode: a nibble > 9 decodes to dash; nibbles 0..9 use the table.
- Leading-zero blanking, when lzb_r=1:
  - Digit i is blanked if data_r nibble i and all higher nibbles are 0.
  - Digit 0 is never blanked by this rule, so all-zero data shows a single "0".
  - A dash digit (nonzero nibble) stops blanking of lower digits.
- Blink prescaler:
  - A counter runs 0..BLINK_DIV-1 continuously.
  - At terminal count it wraps to 0 and blink_phase toggles.
  - Counter width is clog2(BLINK_DIV).
  - load does not reset the counter or the phase.
- Output priority per digit, highest first:
  1. Reset → blank.
  2. mask_r[i] & blink_phase → blank.
  3. Leading-zero blank → blank.
  4. Decoded glyph.
- hex is fully registered. There is no combinational path from inputs to hex.

## Timing
- Reset (rst=1 at an edge):
  - data_r = 0, dec_r = 0, lzb_r = 0, mask_r = 0.
  - Counter = 0, blink_phase = 0.
  - hex = all ones (blank) at the same edge.
- First edge after rst deasserts: hex shows "0" on every digit.
- Latency: load sampled at edge t → new hex valid after edge t+1, i.e. 2 cycles from strobe to pins.
- load held high for several cycles: the value on the last cycle of the strobe wins. Each cycle reloads.
- load and a blink toggle at the same edge: both take effect. The edge t+1 output uses the new data and the new phase.
- rst and load together: rst wins. Registers clear and data is discarded.
- blink_phase changes at the edge where the counter wraps. hex reflects the change one edge later.
- Reset mid-blink restarts the prescaler from 0 with phase 0, which is the visible phase.

## Test plan
- **Reset:** assert rst 2 cycles → hex = all ones. Release → next edge each digit = 1000000, blink_phase = 0.
- **Hex decode:** NUM_DIGITS=8, load data=32'hFEDC_BA98, dec_mode=0. Two cycles later check:
  - digit0 = 0000000 (8), digit1 = 0010000 (9), digit2 = 0001000 (A)
  - digit7 = 0001110 (F)
- **Decimal mode:** load data=32'h0000_1A35, dec_mode=1 → digit0 = 0010010 (5), digit1 = 0110000 (3), digit2 = 0111111 (dash), digit3 = 1111001 (1).
- **Leading-zero blank:**
  - Load 32'h0000_0102, lzb_en=1 → digits 3..7 blank; digit2 = 1111001 (1), digit1 = 1000000 (0), digit0 = 0100100 (2).
  - Then load 32'h0 → only digit0 = 1000000.
- **Blink:** BLINK_DIV=4, blink_mask=8'h01, data=8'h77.
  - digit0 alternates between 1111000 (7) and blank every 4 cycles; digit1 stays steady at 7.
  - blink_phase toggles every 4 cycles.
- **Collisions:**
  - rst and load in the same cycle → hex blank, data_r = 0.
  - load in the cycle the counter wraps → next output has new data with the toggled phase.
